// File: rtl/scalar_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : scalar_ram_arbiter
//  Brief    : Two-port arbiter for the single-port scalar data RAM with locked
//             bursts, starvation release and tagged 1-cycle read return.
//             Define SCALAR_ARB_RR_EN for round-robin conflict resolution;
//             the default build uses fixed priority (port 0 wins).
//  Revision : 1.0 - initial release
// ============================================================================
module scalar_ram_arbiter #(
  parameter int N        = 24,
  parameter int AW       = 14,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r1_req,
  input  logic          r0_we,
  input  logic          r1_we,
  input  logic          r0_lock,
  input  logic          r1_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [AW-1:0] r1_addr,
  input  logic [N-1:0]  r0_wdata,
  input  logic [N-1:0]  r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [N-1:0]  r0_rdata,
  output logic [N-1:0]  r1_rdata,
  output logic [AW-1:0] ram_address,
  output logic [N-1:0]  ram_data,
  output logic          ram_wren,
  input  logic [N-1:0]  ram_q
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_LOCK0    = 2'd1;
  localparam logic [1:0] c_LOCK1    = 2'd2;
  localparam logic [4:0] c_LOCK_MAX = 5'(LOCK_MAX);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [4:0] r_lock_cnt;
  logic [4:0] w_lock_cnt_nxt;
  logic       r_last_gnt;
  logic       r_rvalid0;
  logic       r_rvalid1;
  logic       w_exit;
  logic       w_force;
  logic       w_arb;
  logic       w_pick1;
  logic       w_gnt0;
  logic       w_gnt1;

  // State register; reset drops any lock and discards an in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_lock_cnt <= 5'd0;
      r_last_gnt <= 1'b1;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_gnt0 | w_gnt1)
        r_last_gnt <= w_gnt1;
      r_rvalid0  <= w_gnt0 & ~r0_we;
      r_rvalid1  <= w_gnt1 & ~r1_we;
    end
  end

  // Next-state: any cycle that arbitrates can start a new lock.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_arb) begin
      if (w_gnt0 & r0_lock) begin
        w_state_nxt    = c_LOCK0;
        w_lock_cnt_nxt = 5'd1;
      end else if (w_gnt1 & r1_lock) begin
        w_state_nxt    = c_LOCK1;
        w_lock_cnt_nxt = 5'd1;
      end else begin
        w_state_nxt    = c_IDLE;
        w_lock_cnt_nxt = 5'd0;
      end
    end else if (r_lock_cnt != c_LOCK_MAX) begin
      w_lock_cnt_nxt = r_lock_cnt + 5'd1;
    end
  end

  // Grant logic: a lock exit or starvation release arbitrates in the same cycle.
  always_comb begin
    w_exit  = 1'b0;
    w_force = 1'b0;
    case (r_state)
      c_LOCK0: begin
        w_exit  = ~r0_req | ~r0_lock;
        w_force = (r_lock_cnt == c_LOCK_MAX) & r1_req;
      end
      c_LOCK1: begin
        w_exit  = ~r1_req | ~r1_lock;
        w_force = (r_lock_cnt == c_LOCK_MAX) & r0_req;
      end
      default: ;
    endcase
    w_arb = (r_state == c_IDLE) | w_exit | w_force;

    if (w_force)
      w_pick1 = (r_state == c_LOCK0);
    else
`ifdef SCALAR_ARB_RR_EN
      w_pick1 = ~r_last_gnt;
`else
      w_pick1 = 1'b0;
`endif

    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (w_arb) begin
        if (r0_req & r1_req) begin
          w_gnt0 = ~w_pick1;
          w_gnt1 = w_pick1;
        end else begin
          w_gnt0 = r0_req;
          w_gnt1 = r1_req;
        end
      end else if (r_state == c_LOCK0) begin
        w_gnt0 = r0_req;
      end else begin
        w_gnt1 = r1_req;
      end
    end
  end

  assign r0_gnt      = w_gnt0;
  assign r1_gnt      = w_gnt1;
  assign ram_address = w_gnt1 ? r1_addr  : r0_addr;
  assign ram_data    = w_gnt1 ? r1_wdata : r0_wdata;
  assign ram_wren    = (w_gnt0 & r0_we) | (w_gnt1 & r1_we);
  assign r0_rvalid   = r_rvalid0;
  assign r1_rvalid   = r_rvalid1;
  assign r0_rdata    = r_rvalid0 ? ram_q : '0;
  assign r1_rdata    = r_rvalid1 ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_scalar_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scalar_ram_arbiter
//  Brief    : Directed self-checking bench for scalar_ram_arbiter with a
//             behavioural 1-cycle-latency RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scalar_ram_arbiter;

`ifdef SCALAR_ARB_RR_EN
  localparam bit c_RR = 1'b1;
`else
  localparam bit c_RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock;
  logic [13:0] r0_addr, r1_addr;
  logic [23:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [23:0] r0_rdata, r1_rdata;
  logic [13:0] ram_address;
  logic [23:0] ram_data;
  logic        ram_wren;
  logic [23:0] ram_q;

  logic [23:0] mem [0:16383];

  int n_checks = 0;
  int n_pass   = 0;

  scalar_ram_arbiter #(.N(24), .AW(14), .LOCK_MAX(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .r0_req      (r0_req),
    .r1_req      (r1_req),
    .r0_we       (r0_we),
    .r1_we       (r1_we),
    .r0_lock     (r0_lock),
    .r1_lock     (r1_lock),
    .r0_addr     (r0_addr),
    .r1_addr     (r1_addr),
    .r0_wdata    (r0_wdata),
    .r1_wdata    (r1_wdata),
    .r0_gnt      (r0_gnt),
    .r1_gnt      (r1_gnt),
    .r0_rvalid   (r0_rvalid),
    .r1_rvalid   (r1_rvalid),
    .r0_rdata    (r0_rdata),
    .r1_rdata    (r1_rdata),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren)
      mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0; r0_lock = 0; r1_lock = 0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
  endtask

  initial begin
    idle_all();
    ram_q = '0;
    rst_n = 1'b0;

    // Reset: grants and write enable forced low even with requests present
    #2;
    r0_req = 1; r0_we = 1; r1_req = 1;
    #1;
    check("rst_g0", r0_gnt, 0);
    check("rst_g1", r1_gnt, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_rv0", r0_rvalid, 0);
    check("rst_rv1", r1_rvalid, 0);
    check("rst_rd1", r1_rdata, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    idle_all();

    // Port 0 write, port 1 reads it back
    cyc();
    r0_req = 1; r0_we = 1; r0_addr = 14'h0010; r0_wdata = 24'hABCDEF;
    #1;
    check("wr_g0", r0_gnt, 1);
    check("wr_g1", r1_gnt, 0);
    check("wr_wren", ram_wren, 1);
    check("wr_addr", ram_address, 14'h0010);
    check("wr_data", ram_data, 24'hABCDEF);
    cyc();
    idle_all();
    r1_req = 1; r1_we = 0; r1_addr = 14'h0010;
    #1;
    check("rd_g1", r1_gnt, 1);
    check("rd_g0", r0_gnt, 0);
    check("rd_wren", ram_wren, 0);
    check("rd_addr", ram_address, 14'h0010);
    check("rd_rv0_wr", r0_rvalid, 0);
    cyc();
    idle_all();
    #1;
    check("rd_rv1", r1_rvalid, 1);
    check("rd_rdata1", r1_rdata, 24'hABCDEF);
    check("rd_rv0", r0_rvalid, 0);
    check("rd_rdata0", r0_rdata, 0);

    // Port 1 holds req during a port 0 write
    cyc();
    r0_req = 1; r0_we = 1; r0_addr = 14'h0020; r0_wdata = 24'h123456;
    r1_req = 1; r1_we = 0; r1_addr = 14'h0030;
    #1;
    check("hold_g0", r0_gnt, 1);
    check("hold_g1", r1_gnt, 0);
    check("hold_wren", ram_wren, 1);
    check("hold_addr", ram_address, 14'h0020);
    cyc();
    r0_req = 0;
    #1;
    check("hold2_g1", r1_gnt, 1);
    check("hold2_wren", ram_wren, 0);
    check("hold2_addr", ram_address, 14'h0030);
    cyc();
    r1_req = 0; r0_we = 1;
    #1;
    check("nogrant_wren", ram_wren, 0);
    check("nogrant_g0", r0_gnt, 0);
    check("nogrant_g1", r1_gnt, 0);

    // Both ports read every cycle for 6 cycles
    for (int i = 0; i < 6; i++) begin
      cyc();
      idle_all();
      r0_req = 1; r1_req = 1; r0_addr = 14'(i); r1_addr = 14'(100 + i);
      #1;
      check("both_g0", r0_gnt, c_RR ? ((i % 2) == 0) : 1);
      check("both_g1", r1_gnt, c_RR ? ((i % 2) == 1) : 0);
    end
    cyc();
    idle_all();

    // Port 0 lock burst; port 1 is held off, then wins once lock drops
    for (int i = 0; i < 4; i++) begin
      cyc();
      r0_req = 1; r0_we = 1; r0_lock = 1; r0_addr = 14'(64 + i); r0_wdata = 24'(i);
      r1_req = (i == 3);
      #1;
      check("lk0_g0", r0_gnt, 1);
      check("lk0_g1", r1_gnt, 0);
    end
    cyc();
    r0_req = 0; r0_lock = 0; r0_we = 0;
    r1_req = 1; r1_we = 0; r1_addr = 14'h0040;
    #1;
    check("lk0_exit_g1", r1_gnt, 1);
    check("lk0_exit_g0", r0_gnt, 0);
    cyc();
    idle_all();

    // Port 1 locked write burst against a continuously waiting port 0
    for (int c = 1; c <= 18; c++) begin
      cyc();
      r1_req = 1; r1_we = 1; r1_lock = 1; r1_addr = 14'(200 + c); r1_wdata = 24'(c);
      r0_req = (c >= 2 && c <= 17); r0_we = 1; r0_addr = 14'h0099;
      #1;
      check("starve_g1", r1_gnt, c != 17);
      check("starve_g0", r0_gnt, c == 17);
    end
    cyc();
    idle_all();

    // Reset while locked with a read in flight
    cyc();
    r1_req = 1; r1_we = 0; r1_lock = 1; r1_addr = 14'h0005;
    #1;
    check("rl_g1a", r1_gnt, 1);
    cyc();
    #1;
    check("rl_g1b", r1_gnt, 1);
    cyc();
    check("rl_rv1_pre", r1_rvalid, 1);
    rst_n = 1'b0;
    r0_req = 1; r0_we = 0; r0_addr = 14'h0010;
    #1;
    check("rl_rv1_rst", r1_rvalid, 0);
    check("rl_rd1_rst", r1_rdata, 0);
    check("rl_g0_rst", r0_gnt, 0);
    check("rl_g1_rst", r1_gnt, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("rl_post_g0", r0_gnt, 1);
    check("rl_post_g1", r1_gnt, 0);
    check("rl_post_rv1", r1_rvalid, 0);
    cyc();
    idle_all();
    #1;
    check("rl_post_rv0", r0_rvalid, 1);
    check("rl_post_rd0", r0_rdata, 24'hABCDEF);
    check("rl_post_rv1b", r1_rvalid, 0);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
